dsp_sop_lane_accumulator: RTL and testbench
===========================================

// Module: dsp_sop_lane_accumulator
// PURPOSE
//  Downstream consumer of the 8-lane dsp_chain_3_int_sop_3 array. Takes the packed 8 x 37-bit signed
//  sum-of-products bus, accumulates each lane independently over ACC_BEATS input beats, then rounds,
//  shifts and saturates each lane to OUT_W bits. Results go out on a valid/ready interface to the next stage.
// PARAMETERS
//  LANES      8   number of independent lanes (one per upstream chain instance)
//  IN_W       37  signed width of one upstream lane result
//  ACC_BEATS  4   input beats summed per output group; >=2
//  SHIFT      8   arithmetic right shift applied after rounding; 0 = no rounding
//  OUT_W      16  signed width of one output lane
// PORTS
//  clk        in   1              single clock, rising edge
//  reset      in   1              asynchronous, active-low reset
//  in_valid   in   1              in_data holds a beat
//  in_ready   out  1              beat accepted when in_valid && in_ready
//  in_data    in   LANES*IN_W     lane i at [i*IN_W +: IN_W], two's complement
//  out_valid  out  1              out_data/out_sat hold a result group
//  out_ready  in   1              group consumed when out_valid && out_ready
//  out_data   out  LANES*OUT_W    lane i at [i*OUT_W +: OUT_W], two's complement
//  out_sat    out  LANES          bit i = lane i saturated in this group
// BEHAVIOUR
//  - ACC_W = IN_W + clog2(ACC_BEATS) (39 at defaults). Inputs are sign-extended, so accumulation never wraps.
//  - beat_cnt counts 0..ACC_BEATS-1. An accepted beat with cnt<ACC_BEATS-1 adds the beat into acc[i] and
//    increments cnt. The first beat of a group loads the beat instead of adding it.
//  - Last beat (cnt==ACC_BEATS-1) accepted at edge E: acc[i]+beat goes into rnd_q[i], rnd_v=1, cnt=0.
//    The accumulators are free for the next group in the following cycle.
//  - Round stage advances when rnd_v && (!out_valid || out_ready).
//    Per lane: r = (rnd_q + (SHIFT? 1<<(SHIFT-1):0)) >>> SHIFT (round half up), then clamp to
//    [-2^(OUT_W-1), 2^(OUT_W-1)-1], with sat=1 when clamped. The result loads out_data/out_sat,
//    out_valid=1 and rnd_v=0.
//  - Latency: last beat accepted in cycle N -> out_valid high in cycle N+2 if output is free.
//    Sustained throughput is 1 group per ACC_BEATS cycles.
//  - in_ready = !(cnt==ACC_BEATS-1 && rnd_v && !(out_valid ... drain)), i.e. a last beat stalls only while
//    rnd_q is occupied and cannot advance this cycle. Non-last beats are always accepted.
//  - Output hold: out_data/out_sat stay stable while out_valid && !out_ready.
//    Same-cycle consume and reload is allowed (out_ready high and rnd_v high -> new group next cycle, no bubble).
//  - Reset (any time, including mid-group): acc, rnd_q, cnt, rnd_v, out_valid, out_data and out_sat all go to 0.
//    in_ready=1 on the first cycle after release. A partial group is discarded.
//  - in_data is ignored when !in_valid. X on in_data without in_valid must not propagate.
// CONFIGURATION
//  DSP_SOP_ACC_RELU_EN defined: after saturation each lane with negative r outputs 0.
//    The ReLU clamp does not set out_sat; only the range clamp does.
//  Undefined: signed saturated value passed through unchanged.
// STRUCTURE
//  Package dsp_sop_acc_pkg holds:
//    - acc_w(in_w, beats) function
//    - round-constant function
//    - localparam defaults for LANES/IN_W
//  Sub-module dsp_sop_round_sat: combinational per-lane round+shift+saturate(+ReLU), ports rnd_in[ACC_W],
//  res[OUT_W], sat. Instantiated LANES times by generate. The beat counter and handshake stay in the top.
// TESTING (defaults: ACC_BEATS=4, SHIFT=8, OUT_W=16)
//  1 All lanes 256 for 4 beats, out_ready=1 -> acc 1024, out_data every lane 4, out_sat=0,
//    out_valid exactly cycle N+2.
//  2 Lane0 2^35 x4, lane1 -2^35 x4 -> lane0 32767, lane1 -32768, out_sat=8'b0000_0011.
//  3 Lane0 -384 then three 0 beats -> out lane0 = -1 (RELU_EN off), 0 with out_sat[0]=0 (RELU_EN on).
//  4 out_ready=0 for 12 cycles, continuous in_valid. Result:
//    - first group is held stable
//    - group 2 completes into rnd_q
//    - beats 1-3 of group 3 are accepted
//    - in_ready=0 on beat 4
//    - raising out_ready releases groups in order with no loss.
//  5 Reset asserted after 2 beats of 1000, then released and 4 beats of 256 applied
//    -> result 4 (no carry-over), out_valid=0 during reset.
//  6 Random in_valid/out_ready 50% for 10k beats vs. reference model -> zero mismatches,
//    no out_data change while stalled.

Source files
------------

// File: rtl/dsp_sop_acc_pkg.sv
// Shared sizing helpers and default lane geometry for the SOP lane accumulator.
// Included by dsp_sop_lane_accumulator and dsp_sop_round_sat.
package dsp_sop_acc_pkg;

  localparam int unsigned DEF_LANES = 8;
  localparam int unsigned DEF_IN_W  = 37;

  // Accumulator width that cannot wrap when summing `beats` sign-extended inputs.
  function automatic int unsigned acc_w(input int unsigned in_w, input int unsigned beats);
    return in_w + $clog2(beats);
  endfunction

  // Round-half-up bias added before an arithmetic right shift.
  function automatic logic [63:0] round_const(input int unsigned shift);
    return (shift == 0) ? 64'd0 : (64'd1 << (shift - 1));
  endfunction

endpackage

// File: rtl/dsp_sop_round_sat.sv
// Combinational per-lane round-half-up, arithmetic shift and signed saturation.
// Optional ReLU clamp enabled by DSP_SOP_ACC_RELU_EN (does not affect sat).
module dsp_sop_round_sat
  import dsp_sop_acc_pkg::*;
#(
  parameter int unsigned ACC_W = 39,
  parameter int unsigned SHIFT = 8,
  parameter int unsigned OUT_W = 16
) (
  input  logic signed [ACC_W-1:0] rnd_in,
  output logic signed [OUT_W-1:0] res,
  output logic                    sat
);

  // One guard bit so the rounding bias cannot overflow the most positive sum.
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic signed [SUM_W-1:0] RC   = SUM_W'(round_const(SHIFT));
  localparam logic signed [SUM_W-1:0] MAXV = {{(SUM_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] MINV = {{(SUM_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [SUM_W-1:0] biased;
  logic signed [SUM_W-1:0] shifted;

  always_comb begin
    biased  = SUM_W'(rnd_in) + RC;
    shifted = biased >>> SHIFT;
    sat     = 1'b0;
    res     = shifted[OUT_W-1:0];
    if (shifted > MAXV) begin
      res = MAXV[OUT_W-1:0];
      sat = 1'b1;
    end else if (shifted < MINV) begin
      res = MINV[OUT_W-1:0];
      sat = 1'b1;
    end
`ifdef DSP_SOP_ACC_RELU_EN
    if (res[OUT_W-1]) begin
      res = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/dsp_sop_lane_accumulator.sv
// Per-lane accumulation of ACC_BEATS sum-of-products beats, then round/shift/saturate
// to OUT_W behind valid/ready. Optional ReLU via DSP_SOP_ACC_RELU_EN (in dsp_sop_round_sat).
module dsp_sop_lane_accumulator
  import dsp_sop_acc_pkg::*;
#(
  parameter int unsigned LANES     = DEF_LANES,
  parameter int unsigned IN_W      = DEF_IN_W,
  parameter int unsigned ACC_BEATS = 4,
  parameter int unsigned SHIFT     = 8,
  parameter int unsigned OUT_W     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [LANES*IN_W-1:0]    in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [LANES*OUT_W-1:0]   out_data,
  output logic [LANES-1:0]         out_sat
);

  localparam int unsigned ACC_W = acc_w(IN_W, ACC_BEATS);
  localparam int unsigned CNT_W = $clog2(ACC_BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACC_BEATS - 1);

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic signed [ACC_W-1:0] acc_q [LANES];
  logic signed [ACC_W-1:0] acc_d [LANES];
  logic signed [ACC_W-1:0] rnd_q [LANES];
  logic signed [ACC_W-1:0] rnd_d [LANES];
  logic signed [ACC_W-1:0] beat  [LANES];
  logic signed [ACC_W-1:0] sum   [LANES];
  logic                    rnd_v_q, rnd_v_d;
  logic                    out_valid_q, out_valid_d;
  logic [LANES*OUT_W-1:0]  out_data_q, out_data_d;
  logic [LANES-1:0]        out_sat_q, out_sat_d;
  logic [LANES*OUT_W-1:0]  rs_data;
  logic [LANES-1:0]        rs_sat;
  logic                    last, rnd_adv, accept;

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    dsp_sop_round_sat #(
      .ACC_W (ACC_W),
      .SHIFT (SHIFT),
      .OUT_W (OUT_W)
    ) u_rs (
      .rnd_in (rnd_q[g]),
      .res    (rs_data[g*OUT_W +: OUT_W]),
      .sat    (rs_sat[g])
    );
  end

  assign last      = (cnt_q == LAST_CNT);
  assign rnd_adv   = rnd_v_q && (!out_valid_q || out_ready);
  // A last beat only stalls when rnd_q is full and cannot drain this cycle.
  assign in_ready  = !(last && rnd_v_q && !rnd_adv);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

  always_comb begin
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    rnd_d       = rnd_q;
    rnd_v_d     = rnd_v_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    for (int unsigned i = 0; i < LANES; i++) begin
      beat[i] = in_valid ? ACC_W'($signed(in_data[i*IN_W +: IN_W])) : '0;
      sum[i]  = (cnt_q == '0) ? beat[i] : acc_q[i] + beat[i];
    end
    if (rnd_adv) begin
      rnd_v_d     = 1'b0;
      out_valid_d = 1'b1;
      out_data_d  = rs_data;
      out_sat_d   = rs_sat;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
    if (accept) begin
      if (last) begin
        rnd_d   = sum;
        rnd_v_d = 1'b1;
        cnt_d   = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q       <= '0;
      acc_q       <= '{default: '0};
      rnd_q       <= '{default: '0};
      rnd_v_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= '0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      rnd_q       <= rnd_d;
      rnd_v_q     <= rnd_v_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
    end
  end

endmodule

// File: tb/tb_dsp_sop_lane_accumulator.sv
// Scoreboard bench for dsp_sop_lane_accumulator: directed cases plus randomized
// valid/ready traffic checked against an arithmetic reference model.
module tb_dsp_sop_lane_accumulator;

  localparam int LANES     = 8;
  localparam int IN_W      = 37;
  localparam int OUT_W     = 16;
  localparam int ACC_BEATS = 4;
  localparam int SHIFT     = 8;
  localparam int DW        = LANES * IN_W;
  localparam int OW        = LANES * OUT_W;

  logic            clk = 1'b0;
  logic            reset;
  logic            in_valid;
  logic            in_ready;
  logic [DW-1:0]   in_data;
  logic            out_valid;
  logic            out_ready;
  logic [OW-1:0]   out_data;
  logic [LANES-1:0] out_sat;

  always #5 clk = ~clk;

  dsp_sop_lane_accumulator #(
    .LANES     (LANES),
    .IN_W      (IN_W),
    .ACC_BEATS (ACC_BEATS),
    .SHIFT     (SHIFT),
    .OUT_W     (OUT_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat)
  );

  typedef struct {
    logic [OW-1:0]    data;
    logic [LANES-1:0] sat;
  } exp_t;

  exp_t   sb[$];
  int     total = 0;
  int     bad   = 0;
  longint macc[LANES];
  int     mcnt  = 0;
  bit     rnd_rdy = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: sum the group, round half up, shift, clamp, optional ReLU.
  function automatic exp_t model_group();
    exp_t   e;
    longint rc, r, hi, lo;
    rc = 0;
    if (SHIFT > 0) rc = longint'(1) << (SHIFT - 1);
    hi = (longint'(1) << (OUT_W - 1)) - 1;
    lo = -(longint'(1) << (OUT_W - 1));
    e.data = '0;
    e.sat  = '0;
    for (int i = 0; i < LANES; i++) begin
      r = (macc[i] + rc) >>> SHIFT;
      if (r > hi) begin
        r = hi;
        e.sat[i] = 1'b1;
      end else if (r < lo) begin
        r = lo;
        e.sat[i] = 1'b1;
      end
`ifdef DSP_SOP_ACC_RELU_EN
      if (r < 0) r = 0;
`else
`endif
      e.data[i*OUT_W +: OUT_W] = r[OUT_W-1:0];
    end
    return e;
  endfunction

  task automatic model_beat(input logic [DW-1:0] d);
    logic signed [IN_W-1:0] t;
    longint v;
    for (int i = 0; i < LANES; i++) begin
      t = d[i*IN_W +: IN_W];
      v = t;
      if (mcnt == 0) macc[i] = v;
      else           macc[i] = macc[i] + v;
    end
    mcnt++;
    if (mcnt == ACC_BEATS) begin
      sb.push_back(model_group());
      mcnt = 0;
    end
  endtask

  function automatic logic [IN_W-1:0] rand_lane();
    int v;
    case ($urandom_range(0, 3))
      0: return IN_W'({$urandom, $urandom});
      1: begin v = int'($urandom_range(0, 4000)) - 2000; return IN_W'(v); end
      2: return $urandom_range(0, 1) ? {1'b0, {(IN_W-1){1'b1}}} : {1'b1, {(IN_W-1){1'b0}}};
      default: begin v = int'($urandom) >>> 12; return IN_W'(v); end
    endcase
  endfunction

  function automatic logic [DW-1:0] rand_bus();
    logic [DW-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*IN_W +: IN_W] = rand_lane();
    return b;
  endfunction

  function automatic logic [DW-1:0] fill_bus(input logic [IN_W-1:0] v);
    logic [DW-1:0] b;
    for (int i = 0; i < LANES; i++) b[i*IN_W +: IN_W] = v;
    return b;
  endfunction

  // Entered and left at posedge+1; the beat is accepted at the edge after a negedge with in_ready.
  task automatic drive_beat(input logic [DW-1:0] d, output int waits);
    in_valid = 1'b1;
    in_data  = d;
    waits    = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      waits++;
      if (waits > 1000) begin
        total++;
        bad++;
        $display("FAIL accept_timeout actual=no_accept required=accept");
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    model_beat(d);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = rand_bus();
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 || out_valid) begin
      @(negedge clk);
      n++;
      if (n > 2000) begin
        total++;
        bad++;
        $display("FAIL drain_timeout actual=%0d required=0", sb.size());
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every handshake and checks output hold under stall.
  initial begin : monitor
    exp_t             e;
    logic [OW-1:0]    hd;
    logic [LANES-1:0] hs;
    bit               hold;
    hold = 1'b0;
    forever begin
      @(negedge clk);
      if (hold) begin
        chk("hold_valid", 128'(out_valid), 128'(1));
        chk("hold_data", 128'(out_data), 128'(hd));
        chk("hold_sat", 128'(out_sat), 128'(hs));
      end
      hold = out_valid && !out_ready && reset;
      hd   = out_data;
      hs   = out_sat;
      if (reset && out_valid && out_ready) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_group actual=%h required=none", out_data);
        end else begin
          e = sb.pop_front();
          chk("grp_data", 128'(out_data), 128'(e.data));
          chk("grp_sat", 128'(out_sat), 128'(e.sat));
        end
      end
    end
  end

  initial begin : rdy_gen
    forever begin
      @(posedge clk); #1;
      if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin : main
    int            w;
    logic [DW-1:0] d;
    logic [DW-1:0] d12;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = rand_bus();
    out_ready = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_data", 128'(out_data), 128'(0));
    chk("rst_sat", 128'(out_sat), 128'(0));
    @(posedge clk); #1;
    reset = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;

    // Group of 256s with a free output: result 4 in every lane, valid two cycles after the last beat.
    out_ready = 1'b1;
    for (int b = 0; b < ACC_BEATS; b++) drive_beat(fill_bus(IN_W'(256)), w);
    @(negedge clk);
    chk("lat_n1_valid", 128'(out_valid), 128'(0));
    @(negedge clk);
    chk("lat_n2_valid", 128'(out_valid), 128'(1));
    chk("t1_data", 128'(out_data), 128'({LANES{16'd4}}));
    chk("t1_sat", 128'(out_sat), 128'(0));
    @(posedge clk); #1;
    wait_drain();

    // Saturation at both rails.
    d = '0;
    d[0*IN_W +: IN_W] = IN_W'(longint'(1) << 35);
    d[1*IN_W +: IN_W] = IN_W'(-(longint'(1) << 35));
    for (int b = 0; b < ACC_BEATS; b++) drive_beat(d, w);
    wait_drain();

    // Small negative rounding: -384 -> -1 (0 with ReLU).
    d = '0;
    d[IN_W-1:0] = IN_W'(-384);
    drive_beat(d, w);
    for (int b = 1; b < ACC_BEATS; b++) drive_beat('0, w);
    wait_drain();

    // Backpressure: group 1 held, group 2 in the round stage, group 3 stalls on its last beat.
    out_ready = 1'b0;
    for (int b = 0; b < 3 * ACC_BEATS - 1; b++) begin
      drive_beat(rand_bus(), w);
      chk("bp_accept_wait", 128'(w), 128'(0));
    end
    d12      = rand_bus();
    in_valid = 1'b1;
    in_data  = d12;
    @(negedge clk);
    chk("bp_stall_ready", 128'(in_ready), 128'(0));
    fork
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join_none
    drive_beat(d12, w);
    wait_drain();

    // Reset mid-group discards the partial sum.
    for (int b = 0; b < 2; b++) drive_beat(fill_bus(IN_W'(1000)), w);
    reset = 1'b0;
    mcnt  = 0;
    @(negedge clk);
    chk("mid_rst_valid", 128'(out_valid), 128'(0));
    chk("mid_rst_data", 128'(out_data), 128'(0));
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    chk("mid_rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk); #1;
    for (int b = 0; b < ACC_BEATS; b++) drive_beat(fill_bus(IN_W'(256)), w);
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_result", 128'(out_data), 128'({LANES{16'd4}}));
    @(posedge clk); #1;
    wait_drain();

    // Random traffic with random backpressure.
    rnd_rdy = 1'b1;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
      drive_beat(rand_bus(), w);
    end
    rnd_rdy = 1'b0;
    @(posedge clk); #2;
    out_ready = 1'b1;
    wait_drain();
    chk("sb_empty", 128'(sb.size()), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
